// File: rtl/exe_divider.sv
// Iterative 32-bit radix-2 restoring divider for MIPS DIV/DIVU in the EXE stage.
// Optional build macro DIV_EARLY_OUT_EN skips the iteration when |dividend| < |divisor|.
module exe_divider #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              EXE_Flush,
   input  logic              div_start,
   input  logic              div_signed,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   input  logic              res_ack,
   output logic              div_busy,
   output logic              div_done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] rem, quo, dvsr;
   logic              sign_q, sign_r;

   logic [DATA_W-1:0] abs_a, abs_b;
   logic              start_ok, early;
   logic [DATA_W:0]   rem_sh;
   logic              ge;
   logic [DATA_W-1:0] rem_step, quo_step;

   // 0x80000000 negates to itself and is then treated as an unsigned magnitude.
   assign abs_a    = (div_signed && dividend[DATA_W-1]) ? -dividend : dividend;
   assign abs_b    = (div_signed && divisor[DATA_W-1])  ? -divisor  : divisor;
   assign start_ok = div_start && !EXE_Flush;

`ifdef DIV_EARLY_OUT_EN
   assign early = (abs_a < abs_b) && (divisor != '0);
`else
   assign early = 1'b0;
`endif

   // The shifted partial remainder needs 33 bits; the difference always fits in 32.
   assign rem_sh   = {rem, quo[DATA_W-1]};
   assign ge       = rem_sh >= {1'b0, dvsr};
   assign rem_step = ge ? (rem_sh[DATA_W-1:0] - dvsr) : rem_sh[DATA_W-1:0];
   assign quo_step = {quo[DATA_W-2:0], ge};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start_ok) state_nxt = early ? DONE : CALC;
         CALC: if (count == CNT_W'(1)) state_nxt = DONE;
         DONE: if (res_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (EXE_Flush) state_nxt = IDLE;
   end

   assign div_busy = (state != IDLE);
   assign div_done = (state == DONE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count     <= '0;
         rem       <= '0;
         quo       <= '0;
         dvsr      <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         case (state)
            IDLE: if (start_ok) begin
               rem    <= '0;
               quo    <= abs_a;
               dvsr   <= abs_b;
               sign_q <= div_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
               sign_r <= div_signed & dividend[DATA_W-1];
               count  <= CNT_W'(DATA_W);
               if (early) begin
                  quotient  <= '0;
                  remainder <= dividend;
               end
            end
            CALC: begin
               rem   <= rem_step;
               quo   <= quo_step;
               count <= count - CNT_W'(1);
               // The last step writes the sign-corrected result directly.
               if (count == CNT_W'(1)) begin
                  quotient  <= sign_q ? -quo_step : quo_step;
                  remainder <= sign_r ? -rem_step : rem_step;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_exe_divider.sv
// Directed testbench for exe_divider: latency, signed/unsigned results, corners,
// flush, asynchronous reset and the optional early-out path.
module tb_exe_divider;

   logic        clk = 1'b0;
   logic        resetn;
   logic        EXE_Flush;
   logic        div_start;
   logic        div_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        res_ack;
   logic        div_busy;
   logic        div_done;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int applied = 0;
   int miscompares = 0;

`ifdef DIV_EARLY_OUT_EN
   localparam int EARLY_LAT = 1;
`else
   localparam int EARLY_LAT = 33;
`endif

   exe_divider dut (
      .clk(clk), .resetn(resetn), .EXE_Flush(EXE_Flush), .div_start(div_start),
      .div_signed(div_signed), .dividend(dividend), .divisor(divisor), .res_ack(res_ack),
      .div_busy(div_busy), .div_done(div_done), .quotient(quotient), .remainder(remainder)
   );

   always #5 clk = ~clk;

   // Start sampled at edge 0; returns the cycle at which div_done was seen, -1 on timeout.
   task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b, output int lat);
      @(negedge clk);
      div_start = 1'b1; div_signed = sg; dividend = a; divisor = b;
      @(posedge clk);
      #1 div_start = 1'b0;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (div_done) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic ack_result;
      @(negedge clk);
      res_ack = 1'b1;
      @(posedge clk);
      #1 res_ack = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0; EXE_Flush = 1'b0; div_start = 1'b0; div_signed = 1'b0;
      dividend = '0; divisor = '0; res_ack = 1'b0;
      repeat (3) @(posedge clk);
      #2 resetn = 1'b1;
      @(negedge clk);
      applied++;
      if ({div_busy, div_done} !== 2'b00 || quotient !== 32'd0 || remainder !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_state busy/done=%b%b q=%h r=%h, required 00 q=0 r=0",
                  div_busy, div_done, quotient, remainder);
      end
   endtask

   task automatic test_divu_latency;
      @(negedge clk);
      div_start = 1'b1; div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
      @(posedge clk);
      #1 div_start = 1'b0;
      for (int c = 1; c <= 33; c++) begin
         @(negedge clk);
         applied++;
         if (div_busy !== 1'b1 || div_done !== (c == 33)) begin
            miscompares++;
            $display("[TB] FAIL divu_timing cycle %0d busy=%b done=%b, required busy=1 done=%b",
                     c, div_busy, div_done, (c == 33));
         end
      end
      applied++;
      if (quotient !== 32'd14 || remainder !== 32'd2) begin
         miscompares++;
         $display("[TB] FAIL divu_100_7 q=%0d r=%0d, required q=14 r=2", quotient, remainder);
      end
      @(posedge clk);
      @(posedge clk);
      #1 res_ack = 1'b1;
      @(posedge clk);
      #1 res_ack = 1'b0;
      @(negedge clk);
      applied++;
      if (div_busy !== 1'b0 || div_done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL divu_ack cycle 36 busy=%b done=%b, required 0 0", div_busy, div_done);
      end
   endtask

   task automatic test_signed;
      int lat;
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
      applied++;
      if (lat != 33 || quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
         miscompares++;
         $display("[TB] FAIL div_m7_2 lat=%0d q=%h r=%h, required lat=33 q=fffffffd r=ffffffff",
                  lat, quotient, remainder);
      end
      ack_result();
      run_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat);
      applied++;
      if (lat != 33 || quotient !== 32'hFFFF_FFFD || remainder !== 32'd1) begin
         miscompares++;
         $display("[TB] FAIL div_7_m2 lat=%0d q=%h r=%h, required lat=33 q=fffffffd r=1",
                  lat, quotient, remainder);
      end
      ack_result();
   endtask

   task automatic test_corners;
      int lat;
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      applied++;
      if (lat != 33 || quotient !== 32'h8000_0000 || remainder !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL div_overflow lat=%0d q=%h r=%h, required lat=33 q=80000000 r=0",
                  lat, quotient, remainder);
      end
      ack_result();
      run_div(1'b0, 32'h1234_5678, 32'd0, lat);
      applied++;
      if (lat != 33 || quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678) begin
         miscompares++;
         $display("[TB] FAIL divu_by_zero lat=%0d q=%h r=%h, required lat=33 q=ffffffff r=12345678",
                  lat, quotient, remainder);
      end
      // A start request while in DONE must not disturb the held result.
      @(negedge clk);
      div_start = 1'b1; div_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
      @(posedge clk);
      #1 div_start = 1'b0;
      @(negedge clk);
      applied++;
      if (div_done !== 1'b1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678) begin
         miscompares++;
         $display("[TB] FAIL done_ignores_start done=%b q=%h r=%h, required 1 ffffffff 12345678",
                  div_done, quotient, remainder);
      end
      ack_result();
   endtask

   task automatic test_flush;
      int lat;
      logic seen_done;
      seen_done = 1'b0;
      @(negedge clk);
      div_start = 1'b1; div_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10;
      @(posedge clk);
      #1 div_start = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (div_done) seen_done = 1'b1;
      end
      @(posedge clk);
      #1 EXE_Flush = 1'b1;
      @(negedge clk);
      applied++;
      if (div_busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL flush_pre cycle 10 busy=%b, required 1", div_busy);
      end
      @(posedge clk);
      #1 EXE_Flush = 1'b0;
      @(negedge clk);
      if (div_done) seen_done = 1'b1;
      applied++;
      if (div_busy !== 1'b0 || seen_done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_cancel busy=%b done_seen=%b, required 0 0", div_busy, seen_done);
      end
      run_div(1'b0, 32'd9, 32'd3, lat);
      applied++;
      if (lat != 33 || quotient !== 32'd3 || remainder !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL divu_9_3_after_flush lat=%0d q=%0d r=%0d, required lat=33 q=3 r=0",
                  lat, quotient, remainder);
      end
      // Flush wins over a simultaneous acknowledge in DONE.
      @(negedge clk);
      EXE_Flush = 1'b1; res_ack = 1'b1;
      @(posedge clk);
      #1 begin EXE_Flush = 1'b0; res_ack = 1'b0; end
      @(negedge clk);
      applied++;
      if (div_busy !== 1'b0 || div_done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_in_done busy=%b done=%b, required 0 0", div_busy, div_done);
      end
   endtask

   task automatic test_async_reset;
      @(negedge clk);
      div_start = 1'b1; div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
      @(posedge clk);
      #1 div_start = 1'b0;
      repeat (20) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      applied++;
      if ({div_busy, div_done} !== 2'b00 || quotient !== 32'd0 || remainder !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL async_reset busy/done=%b%b q=%h r=%h, required 00 0 0",
                  div_busy, div_done, quotient, remainder);
      end
      #1 resetn = 1'b1;
      @(negedge clk);
      div_start = 1'b1; EXE_Flush = 1'b1; dividend = 32'd20; divisor = 32'd4;
      @(posedge clk);
      #1 begin div_start = 1'b0; EXE_Flush = 1'b0; end
      @(negedge clk);
      applied++;
      if (div_busy !== 1'b0 || div_done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL start_with_flush busy=%b done=%b, required 0 0", div_busy, div_done);
      end
   endtask

   task automatic test_early_out;
      int lat;
      run_div(1'b0, 32'd5, 32'd9, lat);
      applied++;
      if (lat != EARLY_LAT || quotient !== 32'd0 || remainder !== 32'd5) begin
         miscompares++;
         $display("[TB] FAIL divu_5_9 lat=%0d q=%0d r=%0d, required lat=%0d q=0 r=5",
                  lat, quotient, remainder, EARLY_LAT);
      end
      ack_result();
      @(negedge clk);
      applied++;
      if (div_busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL early_ack busy=%b, required 0", div_busy);
      end
   endtask

   initial begin
      test_reset();
      test_divu_latency();
      test_signed();
      test_corners();
      test_flush();
      test_async_reset();
      test_early_out();
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
